// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions used by the execute-stage divider:
//               divider FSM state enumeration, datapath width, nominal
//               latency and the divide-by-zero quotient pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int          DIV_WIDTH     = 32;
    // Rising edges from the accepting edge to out_valid (normal path).
    localparam int          DIV_LATENCY   = 34;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_if
// Description : Request/response bundle between the execute pipeline and the
//               multi-cycle divider.
//   master : pipeline side - drives flush, in_valid, is_signed, dividend,
//            divisor, out_ready; observes in_ready and the result.
//   slave  : divider side  - drives in_ready, out_valid, quotient,
//            remainder, div_by_zero.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output flush, in_valid, is_signed, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  flush, in_valid, is_signed, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface : div_unit_if
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One radix-2 restoring division iteration (combinational).
//               Shifts {rem, quo} left by one, trial-subtracts the divisor
//               from the widened partial remainder and sets the new quotient
//               LSB when the trial is non-negative.
//   i_rem / i_quo / i_divisor : current partial remainder, quotient, divisor
//   o_rem / o_quo             : partial remainder and quotient after the step
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_rem,
    input  wire logic [WIDTH-1:0] i_quo,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH-1:0] o_rem,
    output logic      [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;
    logic           w_neg;

    // rem < divisor holds between steps, so the shifted remainder is below
    // 2*divisor and WIDTH+1 bits are enough for the trial's sign to be exact.
    // With a zero divisor the remainder never reaches bit WIDTH-1 before the
    // last shift, so the trial is always non-negative there as well.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, i_divisor};
    assign w_neg   = w_trial[WIDTH];

    assign o_rem = w_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_neg};

endmodule : div_step
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle DIV/DIVU unit, radix-2 restoring, one quotient
//               bit per cycle. Remainder feeds HI, quotient feeds LO.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : div_unit_if.slave - valid/ready request (flush, in_valid,
//                in_ready, is_signed, dividend, divisor) and held response
//                (out_valid, out_ready, quotient, remainder, div_by_zero)
// Build macro : DIV_ZERO_SHORTCUT_EN - a zero divisor skips the iterations
//               and goes straight to DONE (same result, shorter latency).
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 5
) (
    input wire logic   clk,
    input wire logic   rst_n,
    div_unit_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_FIX  = FIX;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_raw_dvd;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_dz;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;
    logic             r_out_valid;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_dvd_neg;
    logic             w_dsr_neg;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dsr_abs;
    logic             w_dsr_zero;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_in_ready = (r_state == ST_IDLE) && !bus.flush;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Signs only matter for DIV; DIVU treats both operands as magnitudes.
    assign w_dvd_neg  = bus.is_signed && bus.dividend[WIDTH-1];
    assign w_dsr_neg  = bus.is_signed && bus.divisor[WIDTH-1];
    assign w_dvd_abs  = w_dvd_neg ? -bus.dividend : bus.dividend;
    assign w_dsr_abs  = w_dsr_neg ? -bus.divisor  : bus.divisor;
    assign w_dsr_zero = (bus.divisor == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_dsr),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_dsr         <= '0;
            r_raw_dvd     <= '0;
            r_qneg        <= 1'b0;
            r_rneg        <= 1'b0;
            r_dz          <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_out_valid   <= 1'b0;
        end else if (bus.flush) begin
            // Result registers are left as-is; they are meaningless once
            // out_valid is low.
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rem     <= '0;
                        r_quo     <= w_dvd_abs;
                        r_dsr     <= w_dsr_abs;
                        r_qneg    <= w_dvd_neg ^ w_dsr_neg;
                        r_rneg    <= w_dvd_neg;
                        r_raw_dvd <= bus.dividend;
                        r_dz      <= w_dsr_zero;
                        r_cnt     <= '0;
`ifdef DIV_ZERO_SHORTCUT_EN
                        if (w_dsr_zero) begin
                            r_quotient    <= WIDTH'(DIV_ZERO_QUOT);
                            r_remainder   <= bus.dividend;
                            r_div_by_zero <= 1'b1;
                            r_state       <= ST_DONE;
                        end else begin
                            r_state       <= ST_CALC;
                        end
`else
                        r_state   <= ST_CALC;
`endif
                    end
                end

                ST_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST_ITER) begin
                        r_state <= ST_FIX;
                    end
                end

                ST_FIX: begin
                    // Divide-by-zero returns the architectural pattern and
                    // the untouched dividend, so it bypasses sign correction.
                    if (r_dz) begin
                        r_quotient  <= WIDTH'(DIV_ZERO_QUOT);
                        r_remainder <= r_raw_dvd;
                    end else begin
                        r_quotient  <= r_qneg ? -r_quo : r_quo;
                        r_remainder <= r_rneg ? -r_rem : r_rem;
                    end
                    r_div_by_zero <= r_dz;
                    r_state       <= ST_DONE;
                end

                ST_DONE: begin
                    // Results land in the output registers on entry to DONE
                    // and are published one edge later, then held until the
                    // consumer takes them.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit. Expected results come from
//               a 64-bit integer reference model and are queued when an
//               operation is issued, then compared when out_valid appears.
//               Honours DIV_ZERO_SHORTCUT_EN for the divide-by-zero latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;
    import cpu_pkg::*;

    localparam int WIDTH = DIV_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    div_unit_if #(.WIDTH(WIDTH)) bus ();

    div_unit #(
        .WIDTH (WIDTH),
        .CNT_W (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic [31:0] lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint na, nb, q, r;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
`ifdef DIV_ZERO_SHORTCUT_EN
            e.lat = 32'd1;
`else
            e.lat = 32'(DIV_LATENCY);
`endif
            return e;
        end
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'(a);
            nb = longint'(b);
        end
        q     = na / nb;
        r     = na % nb;
        e.q   = q[31:0];
        e.r   = r[31:0];
        e.dz  = 1'b0;
        e.lat = 32'(DIV_LATENCY);
        return e;
    endfunction

    // Entered at a negedge; returns #1 after the accepting edge.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b, input bit push);
        int guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
            return;
        end
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.in_valid  = 1'b1;
        if (push) sb_q.push_back(model(s, a, b));
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        bus.is_signed = 1'($urandom_range(0, 1));
    endtask

    // Called right after start_op; returns at a negedge with the unit idle.
    task automatic collect(input int hold);
        int          lat = 0;
        exp_t        e;
        logic [31:0] q0, r0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.out_valid && lat < 200);
        if (!bus.out_valid) begin
            chk("out_valid_timeout", 64'd0, 64'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = sb_q.pop_front();
        chk("latency",     64'(lat),             64'(e.lat));
        chk("quotient",    64'(bus.quotient),    64'(e.q));
        chk("remainder",   64'(bus.remainder),   64'(e.r));
        chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dz));
        q0 = bus.quotient;
        r0 = bus.remainder;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid",    64'(bus.out_valid), 64'd1);
            chk("hold_in_ready", 64'(bus.in_ready),  64'd0);
            chk("hold_quot",     64'(bus.quotient),  64'(q0));
            chk("hold_rem",      64'(bus.remainder), 64'(r0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("release_valid",    64'(bus.out_valid), 64'd0);
        chk("release_in_ready", 64'(bus.in_ready),  64'd1);
    endtask

    task automatic expect_no_valid(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  64'(bus.in_ready),    64'd1);
        chk("rst_out_valid", 64'(bus.out_valid),   64'd0);
        chk("rst_quotient",  64'(bus.quotient),    64'd0);
        chk("rst_remainder", 64'(bus.remainder),   64'd0);
        chk("rst_dz",        64'(bus.div_by_zero), 64'd0);

        // Directed cases
        start_op(1'b0, 32'd100, 32'd7, 1'b1);                collect(0);
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);          collect(0);
        start_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);          collect(0);
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  collect(0);
        start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  collect(0);
        start_op(1'b1, 32'hFFFF_FFF6, 32'd0, 1'b1);          collect(0);
        start_op(1'b0, 32'd12345, 32'd0, 1'b1);              collect(0);

        // Backpressure plus an in_valid raised while busy
        start_op(1'b0, 32'd5000, 32'd3, 1'b1);
        fork
            collect(10);
            begin
                repeat (3) @(negedge clk);
                bus.dividend  = 32'd99;
                bus.divisor   = 32'd9;
                bus.in_valid  = 1'b1;
                repeat (5) @(negedge clk);
                bus.in_valid  = 1'b0;
            end
        join
        expect_no_valid("busy_req_ignored", 40);

        // flush with in_valid in IDLE: must not be accepted
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.divisor  = 32'd1;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        expect_no_valid("flush_idle_no_accept", 40);

        // flush at CALC iteration 15
        start_op(1'b0, 32'd123456, 32'd7, 1'b0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_to_idle", 64'(bus.in_ready), 64'd1);
        expect_no_valid("flush_no_valid", 50);
        start_op(1'b0, 32'd1000, 32'd10, 1'b1);              collect(0);

        // Asynchronous reset mid-CALC
        start_op(1'b1, 32'hFFFF_0000, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("arst_quotient",  64'(bus.quotient),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_no_valid("arst_no_valid", 50);
        start_op(1'b0, 32'd1000, 32'd10, 1'b1);              collect(0);

        // Random mix
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 5) b = 32'hFFFF_FFFF;
            start_op(1'($urandom_range(0, 1)), a, b, 1'b1);
            collect(i % 3);
        end

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_div_unit
`default_nettype wire
